// File: rtl/qpmm_pkg.sv
// Shared types and default sizing for the QPMM iteration controller.
//   state_t : controller FSM states
//   word_t  : operand/product word at the default width
//   DEPTH   : words per operand RAM at the default address width
package qpmm_pkg;

    localparam int DEF_W       = 272;
    localparam int DEF_AW      = 8;
    localparam int DEF_MUL_LAT = 16;
    localparam int DEF_ITER_W  = 32;
    localparam int DEPTH       = 2 ** DEF_AW;

    typedef logic [DEF_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/qpmm_opram.sv
// Simple dual-port operand RAM: one write port, one registered read port.
// Read-first: a read and a write of the same address in one cycle return the old word.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, valid one cycle after raddr
module qpmm_opram
    import qpmm_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/qpmm_iter_ctrl.sv
// Operand-buffer and iteration engine for a fixed-latency modular multiplier.
// Streams A[i], B[i] for i = 0..n_words-1 into the multiplier, writes each product
// back (to A, or to A and B when mode=1), repeats for n_iter passes and keeps an
// XOR checksum of every product written.
//   clk, rst                        : clock, synchronous active-high reset
//   start, n_words, n_iter, mode    : run request and its configuration (latched at start)
//   ld_we, ld_sel, ld_addr, ld_data : host load port (ignored while busy)
//   rd_sel, rd_addr, rd_data        : host readback, 1-cycle latency, 0 while busy
//   mul_a, mul_b, mul_valid, mul_z  : multiplier interface
//   busy, done, pass_cnt, chk, dout : status
module qpmm_iter_ctrl
    import qpmm_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int AW      = DEF_AW,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int ITER_W  = DEF_ITER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW:0]       n_words,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              mode,
    input  logic              ld_we,
    input  logic              ld_sel,
    input  logic [AW-1:0]     ld_addr,
    input  logic [W-1:0]      ld_data,
    input  logic              rd_sel,
    input  logic [AW-1:0]     rd_addr,
    output logic [W-1:0]      rd_data,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    output logic              mul_valid,
    input  logic [W-1:0]      mul_z,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] pass_cnt,
    output logic [W-1:0]      chk,
    output logic              dout
);

    // Tag travelling alongside each issued operand pair; 'last' marks the final word of a pass.
    typedef struct packed {
        logic          valid;
        logic          last;
        logic [AW-1:0] addr;
    } tag_t;

    state_t            state_reg, state_next;
    logic [AW:0]       nw_reg, nw_next;
    logic [ITER_W-1:0] ni_reg, ni_next;
    logic              mode_reg, mode_next;
    logic [AW-1:0]     i_reg, i_next;
    logic [ITER_W-1:0] pass_reg, pass_next;
    logic [W-1:0]      chk_reg, chk_next;
    logic              done_reg, done_next;
    logic              issue;
    logic              last_read;

    logic              mul_valid_reg, mul_last_reg;
    logic [AW-1:0]     mul_addr_reg;
    logic              rd_valid_reg, rd_sel_reg;

    tag_t              sr_in;
    tag_t              sr [MUL_LAT];
    tag_t              tag_out;
    logic              wr_en;

    logic              a_we, b_we;
    logic [AW-1:0]     ram_waddr, ram_raddr;
    logic [W-1:0]      a_wdata, b_wdata, a_q, b_q;

    assign busy      = (state_reg != ST_IDLE);
    assign last_read = ({1'b0, i_reg} == (nw_reg - (AW+1)'(1)));

    // Valid/address shift register: its output lines up with mul_z of the tagged issue.
    assign sr_in = '{valid: mul_valid_reg, last: mul_last_reg, addr: mul_addr_reg};

    for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) sr[gi] <= '0;
                else     sr[gi] <= sr_in;
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (rst) sr[gi] <= '0;
                else     sr[gi] <= sr[gi-1];
            end
        end
    end

    assign tag_out = sr[MUL_LAT-1];
    // Gating with rst drops any product arriving on the reset edge itself.
    assign wr_en   = tag_out.valid && !rst;

    // While busy the engine owns both RAM ports; otherwise the host does.
    assign ram_waddr = busy ? tag_out.addr : ld_addr;
    assign ram_raddr = busy ? i_reg : rd_addr;
    assign a_we      = busy ? wr_en : (ld_we && !ld_sel);
    assign b_we      = busy ? (wr_en && mode_reg) : (ld_we && ld_sel);
    assign a_wdata   = busy ? mul_z : ld_data;
    assign b_wdata   = busy ? mul_z : ld_data;

    qpmm_opram #(.W(W), .AW(AW)) u_ram_a (
        .clk   (clk),
        .we    (a_we),
        .waddr (ram_waddr),
        .wdata (a_wdata),
        .raddr (ram_raddr),
        .rdata (a_q)
    );

    qpmm_opram #(.W(W), .AW(AW)) u_ram_b (
        .clk   (clk),
        .we    (b_we),
        .waddr (ram_waddr),
        .wdata (b_wdata),
        .raddr (ram_raddr),
        .rdata (b_q)
    );

    always_comb begin
        state_next = state_reg;
        nw_next    = nw_reg;
        ni_next    = ni_reg;
        mode_next  = mode_reg;
        i_next     = i_reg;
        pass_next  = pass_reg;
        chk_next   = chk_reg;
        done_next  = 1'b0;
        issue      = 1'b0;

        if (wr_en) begin
            chk_next = chk_reg ^ mul_z;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    nw_next    = n_words;
                    ni_next    = n_iter;
                    mode_next  = mode;
                    pass_next  = '0;
                    chk_next   = '0;
                    i_next     = '0;
                    state_next = (n_words != '0 && n_iter != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (last_read) begin
                    i_next     = '0;
                    state_next = ST_DRAIN;
                end else begin
                    i_next = i_reg + AW'(1);
                end
            end
            ST_DRAIN: begin
                // The pass ends on the edge that writes its final product.
                if (tag_out.valid && tag_out.last) begin
                    pass_next  = pass_reg + ITER_W'(1);
                    state_next = (pass_next < ni_reg) ? ST_RUN : ST_FIN;
                end
            end
            ST_FIN: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            nw_reg        <= '0;
            ni_reg        <= '0;
            mode_reg      <= 1'b0;
            i_reg         <= '0;
            pass_reg      <= '0;
            chk_reg       <= '0;
            done_reg      <= 1'b0;
            mul_valid_reg <= 1'b0;
            mul_last_reg  <= 1'b0;
            mul_addr_reg  <= '0;
            rd_valid_reg  <= 1'b0;
            rd_sel_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            nw_reg        <= nw_next;
            ni_reg        <= ni_next;
            mode_reg      <= mode_next;
            i_reg         <= i_next;
            pass_reg      <= pass_next;
            chk_reg       <= chk_next;
            done_reg      <= done_next;
            mul_valid_reg <= issue;
            mul_last_reg  <= last_read;
            mul_addr_reg  <= i_reg;
            rd_valid_reg  <= !busy;
            rd_sel_reg    <= rd_sel;
        end
    end

    // RAM outputs are not reset, so present zeros whenever they carry no meaning.
    assign mul_valid = mul_valid_reg;
    assign mul_a     = mul_valid_reg ? a_q : '0;
    assign mul_b     = mul_valid_reg ? b_q : '0;
    assign rd_data   = rd_valid_reg ? (rd_sel_reg ? b_q : a_q) : '0;
    assign done      = done_reg;
    assign pass_cnt  = pass_reg;
    assign chk       = chk_reg;
    assign dout      = chk_reg[0];

endmodule

// File: tb/tb_qpmm_iter_ctrl.sv
// Scoreboard bench for qpmm_iter_ctrl: a behavioural model of the RAM contents predicts
// operand pairs, completion events and readback words; a monitor pops and compares them.
module tb_qpmm_iter_ctrl;
    import qpmm_pkg::*;

    localparam int W  = DEF_W;
    localparam int AW = DEF_AW;
    localparam int ML = DEF_MUL_LAT;
    localparam int IW = DEF_ITER_W;

    logic          clk, rst, start, mode, ld_we, ld_sel, rd_sel;
    logic [AW:0]   n_words;
    logic [IW-1:0] n_iter, pass_cnt;
    logic [AW-1:0] ld_addr, rd_addr;
    word_t         ld_data, rd_data, mul_a, mul_b, mul_z, chk;
    logic          mul_valid, busy, done, dout;

    qpmm_iter_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .n_words(n_words), .n_iter(n_iter),
        .mode(mode), .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .mul_a(mul_a), .mul_b(mul_b),
        .mul_valid(mul_valid), .mul_z(mul_z), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .chk(chk), .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: z = a*b mod 2**W exactly ML cycles after mul_valid; junk otherwise.
    word_t mpipe [ML];
    always @(posedge clk) begin
        mpipe[0] <= mul_valid ? word_t'(mul_a * mul_b) : '1;
        for (int s = 1; s < ML; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mul_z = mpipe[ML-1];

    typedef struct { word_t a; word_t b; } op_t;
    typedef struct { int cycle; int busy_cycles; logic [IW-1:0] pass; word_t chk; } done_t;

    op_t   op_q[$];
    done_t done_q[$];
    word_t rd_q[$];
    logic  rd_req, rd_pend;
    always @(posedge clk) rd_pend <= rd_req;

    word_t ref_a [DEPTH];
    word_t ref_b [DEPTH];
    int    checks = 0;
    int    failures = 0;

    function automatic void check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic word_t rand_word();
        word_t w = '0;
        for (int j = 0; j < 9; j++) w = (w << 32) | word_t'($urandom);
        return w;
    endfunction

    // Monitor: compares whatever the DUT presents against the queued expectations.
    int busy_cnt;
    initial begin
        op_t   o;
        done_t e;
        word_t r;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) busy_cnt = 0;
            else if (busy) busy_cnt++;
            if (mul_valid) begin
                if (op_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_mul_valid actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    o = op_q.pop_front();
                    check("mul_a", mul_a, o.a);
                    check("mul_b", mul_b, o.b);
                end
            end
            if (rd_pend) begin
                r = rd_q.pop_front();
                check("rd_data", rd_data, r);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_done actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    e = done_q.pop_front();
                    check("done_cycle", word_t'(cyc), word_t'(e.cycle));
                    check("pass_cnt", word_t'(pass_cnt), word_t'(e.pass));
                    check("chk", chk, e.chk);
                    check("dout", word_t'(dout), word_t'(e.chk[0]));
                    check("busy_cycles", word_t'(busy_cnt), word_t'(e.busy_cycles));
                    check("busy_at_done", word_t'(busy), '0);
                    check("ops_left_at_done", word_t'(op_q.size()), '0);
                    $display("run done at cycle %0d pass_cnt=%0d chk=%0h", cyc, pass_cnt, chk);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input int addr, input word_t data);
        ld_we = 1'b1; ld_sel = sel; ld_addr = AW'(addr); ld_data = data;
        if (sel) ref_b[addr] = data; else ref_a[addr] = data;
        step();
        ld_we = 1'b0;
    endtask

    task automatic readback(input logic sel, input int addr);
        rd_q.push_back(sel ? ref_b[addr] : ref_a[addr]);
        rd_sel = sel; rd_addr = AW'(addr); rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    task automatic run(input int nw, input int ni, input logic md);
        int    k, bound;
        done_t e;
        word_t z, c;
        k = cyc + 1;
        c = '0;
        if (nw != 0 && ni != 0) begin
            for (int p = 0; p < ni; p++) begin
                for (int i = 0; i < nw; i++) begin
                    op_q.push_back('{a: ref_a[i], b: ref_b[i]});
                    z = word_t'(ref_a[i] * ref_b[i]);
                    ref_a[i] = z;
                    if (md) ref_b[i] = z;
                    c ^= z;
                end
            end
            e.cycle = k + 1 + ni * (nw + ML + 1);
            e.pass  = IW'(ni);
        end else begin
            e.cycle = k + 1;
            e.pass  = '0;
        end
        e.chk = c;
        e.busy_cycles = e.cycle - k;
        done_q.push_back(e);
        $display("start run n_words=%0d n_iter=%0d mode=%0d at edge %0d", nw, ni, md, k);
        start = 1'b1; n_words = (AW+1)'(nw); n_iter = IW'(ni); mode = md;
        step();
        // Configuration is latched; scribbling on it mid-run must not matter.
        start = 1'b0; n_words = (AW+1)'($urandom); n_iter = IW'($urandom); mode = 1'($urandom);
        bound = e.cycle - k + 20;
        while (done_q.size() != 0 && bound > 0) begin
            step();
            bound--;
        end
        if (done_q.size() != 0) begin
            check("done_timeout", word_t'(done_q.size()), '0);
            done_q.delete();
            op_q.delete();
        end
        step();
    endtask

    initial begin
        int nw, ni;
        logic md;
        rst = 1'b1; start = 1'b0; n_words = '0; n_iter = '0; mode = 1'b0;
        ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        rd_sel = 1'b0; rd_addr = '0; rd_req = 1'b0;
        repeat (3) step();
        check("rst_busy", word_t'(busy), '0);
        check("rst_done", word_t'(done), '0);
        check("rst_mul_valid", word_t'(mul_valid), '0);
        check("rst_pass_cnt", word_t'(pass_cnt), '0);
        check("rst_chk", chk, '0);
        check("rst_dout", word_t'(dout), '0);
        check("rst_mul_a", mul_a, '0);
        check("rst_mul_b", mul_b, '0);
        check("rst_rd_data", rd_data, '0);
        rst = 1'b0;
        repeat (10) step();
        check("idle_busy", word_t'(busy), '0);

        // Two passes, A-only writeback: A[0] 5 -> 15 -> 45, chk 15^45.
        load(0, 0, word_t'(5)); load(1, 0, word_t'(3));
        run(1, 2, 1'b0);
        readback(0, 0); readback(1, 0);

        // Three passes writing both RAMs: 2 -> 4 -> 16 -> 256.
        load(0, 0, word_t'(2)); load(1, 0, word_t'(2));
        run(1, 3, 1'b1);
        readback(0, 0); readback(1, 0);

        // Full depth: A[i]=i times 1 leaves A unchanged, chk is the XOR of 0..255.
        for (int i = 0; i < DEPTH; i++) begin
            load(0, i, word_t'(i));
            load(1, i, word_t'(1));
        end
        run(DEPTH, 1, 1'b0);
        for (int i = 0; i < DEPTH; i++) readback(0, i);
        readback(1, 0); readback(1, DEPTH-1);

        // Degenerate requests go straight to completion without issuing.
        run(5, 0, 1'b0);
        run(0, 3, 1'b1);
        readback(0, 3); readback(1, 3);

        // Randomized runs on random operands.
        for (int t = 0; t < 4; t++) begin
            nw = $urandom_range(1, 12);
            ni = $urandom_range(1, 3);
            md = 1'($urandom);
            for (int i = 0; i < nw; i++) begin
                load(0, i, rand_word());
                load(1, i, rand_word());
            end
            run(nw, ni, md);
            for (int i = 0; i < nw; i++) begin
                readback(0, i);
                readback(1, i);
            end
        end

        // Load and readback of the same address in one idle cycle returns the old word.
        rd_q.push_back(ref_a[7]);
        rd_sel = 1'b0; rd_addr = AW'(7); rd_req = 1'b1;
        load(0, 7, rand_word());
        rd_req = 1'b0;
        readback(0, 7);

        // Reset in the 5th RUN cycle; only the first four operand pairs get issued, and
        // no product can land before the reset, so the model state stays untouched.
        for (int i = 0; i < 8; i++) begin
            load(0, i, rand_word());
            load(1, i, rand_word());
        end
        for (int i = 0; i < 4; i++) op_q.push_back('{a: ref_a[i], b: ref_b[i]});
        $display("start run n_words=8 n_iter=2 mode=1 (to be reset)");
        start = 1'b1; n_words = (AW+1)'(8); n_iter = IW'(2); mode = 1'b1;
        step();
        start = 1'b0;
        // Host load and readback while busy: write ignored, readback returns zero.
        ld_we = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = rand_word();
        rd_q.push_back('0);
        rd_sel = 1'b0; rd_addr = '0; rd_req = 1'b1;
        step();
        ld_we = 1'b0; rd_req = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", word_t'(busy), '0);
        check("midrst_mul_valid", word_t'(mul_valid), '0);
        check("midrst_pass_cnt", word_t'(pass_cnt), '0);
        check("midrst_chk", chk, '0);
        check("midrst_ops_left", word_t'(op_q.size()), '0);
        op_q.delete();
        repeat (30) step();
        run(8, 2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            readback(0, i);
            readback(1, i);
        end

        repeat (3) step();
        check("end_ops_left", word_t'(op_q.size()), '0);
        check("end_reads_left", word_t'(rd_q.size()), '0);
        check("end_done_left", word_t'(done_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qpmm_iter_ctrl.md
Name: qpmm_iter_ctrl

Overview:
- Parametrised operand-buffer and iteration engine that feeds a fixed-latency pipelined modular multiplier (QPMM family) from two on-chip operand RAMs (A, B) and writes each product back.
- Replaces the free-running fixed-address test loop with a controlled one: host load/readback, programmable word count, iteration count and writeback mode, plus an XOR checksum.
- Sits between the host/debug logic and the multiplier instance in the board-level test top.

Parameters:
- W, 272, operand/product width in bits.
- AW, 8, address width; each RAM holds 2**AW words.
- MUL_LAT, 16, multiplier latency in cycles from mul_valid to mul_z valid; must be ≥1.
- ITER_W, 32, width of the iteration counter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- n_words  in  AW+1  words per pass, 0..2**AW.
- n_iter  in  ITER_W  number of passes.
- mode  in  1  0: Z→A[i]; 1: Z→A[i] and B[i].
- ld_we  in  1  host write strobe.
- ld_sel  in  1  0 = RAM A, 1 = RAM B.
- ld_addr  in  AW  host write address.
- ld_data  in  W  host write data.
- rd_sel  in  1  readback RAM select.
- rd_addr  in  AW  readback address.
- rd_data  out  W  readback data, 1-cycle latency.
- mul_a  out  W  multiplier operand A.
- mul_b  out  W  multiplier operand B.
- mul_valid  out  1  operands valid this cycle.
- mul_z  in  W  product, valid exactly MUL_LAT cycles after its mul_valid.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- pass_cnt  out  ITER_W  completed passes in the current/last run.
- chk  out  W  XOR of every product written in the current/last run.
- dout  out  1  chk[0], the pin-level observable.

Behaviour:
- Reset: busy, done, mul_valid, pass_cnt and chk = 0; mul_a, mul_b, rd_data = 0; FSM in IDLE. RAM contents are not cleared.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE→RUN on start when n_words≠0 and n_iter≠0; pass_cnt and chk clear on acceptance.
  - start with n_words=0 or n_iter=0 → FIN directly; no mul_valid is issued.
  - start while busy is ignored.
- RUN: read address i = 0..n_words-1, one per cycle from both RAMs (1-cycle read). mul_valid is high the cycle after each read, with mul_a = A[i] and mul_b = B[i].
- Address tracking: a MUL_LAT-deep valid/address shift register tags each issue. The product arriving with a tag writes A[i] (and B[i] if mode=1) and XORs into chk.
- RUN→DRAIN after the last read issue. DRAIN ends on the cycle the final tagged product is written; pass_cnt then increments.
  - If pass_cnt < n_iter, return to RUN with i = 0.
  - Otherwise go to FIN.
- FIN: done = 1 for one cycle, busy drops the same cycle, then IDLE.
- Pass period is n_words+MUL_LAT+1 cycles. No read-after-write hazard exists because the next pass starts only after the drain.
- Timing: with start sampled at edge k, done is asserted at cycle k+1+n_iter*(n_words+MUL_LAT+1).
- n_words, n_iter and mode are latched at start; later changes have no effect on a run in progress.
- Host load and readback:
  - ld_we is ignored while busy.
  - rd_data returns 0 while busy.
  - When not busy, a load and a readback of the same address in the same cycle return the old data.
- rst mid-run: FSM returns to IDLE within one cycle, the shift register is flushed, late mul_z values are discarded, and the RAMs keep partially updated contents.

Decomposition:
- Package qpmm_pkg holds:
  - the state enum typedef;
  - typedef word_t = logic [W-1:0];
  - localparam DEPTH = 2**AW.
- One natural sub-module: qpmm_opram, a simple dual-port W×DEPTH RAM with a write port and a 1-cycle read port, instantiated twice.
- The read port is muxed between the engine and host readback by busy.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0, mul_valid never asserted.
- Bench multiplier model z = a*b mod 2**W, MUL_LAT = 16.
  - Load A[0] = 5, B[0] = 3; run n_words = 1, n_iter = 2, mode = 0.
  - Expected: A[0] = 45, B[0] = 3, chk = 15^45 = 34, dout = 0, pass_cnt = 2, done at k+37.
- Same model, load A[0] = B[0] = 2; run mode = 1, n_iter = 3 → A[0] = B[0] = 256, chk = 4^16^256 = 276.
- Full depth: load A[i] = i, B[i] = 1 for all 256 words; run n_iter = 1 mode 0.
  - Expected: 256 consecutive mul_valid cycles, A unchanged, chk = 0, done at k+274.
- Run with n_iter = 0 → done at k+1, busy one cycle, no mul_valid, RAMs unchanged.
- Assert rst at the 5th cycle of RUN, then restart with the same config.
  - Expected: the first run produces no done; the second run completes at the formula time and writes correct products over the partial state.
  - ld_we pulsed during RUN has no effect on the RAM.
